alu_reg_file: RTL and testbench
===============================

# alu_reg_file

Register file stage directly upstream of the 8-bit ALU. It holds four general registers (R1–R4) and four temporary registers (T1–T4), and applies a shared 2-bit function to any selected subset on each clock edge. It drives two independent combinational read ports, OutA and OutB, which connect to the ALU's A and B inputs. Load data normally comes from OutALU or from memory.

## Interface

Parameters:
- WIDTH, 8, register and data width in bits (ALU operand width).

Ports:
- CLK, in, 1, system clock; all state updates on the rising edge.
- ResetN, in, 1, asynchronous active-low reset.
- I, in, WIDTH, load data (ALU result or memory word).
- FunSel, in, 2, register function: 00 decrement, 01 increment, 10 load I, 11 clear.
- RSel, in, 4, active-high write enables for R1..R4 (bit0 = R1).
- TSel, in, 4, active-high write enables for T1..T4 (bit0 = T1).
- OutASel, in, 3, read select for OutA: 000–011 selects T1–T4, 100–111 selects R1–R4.
- OutBSel, in, 3, read select for OutB, same encoding as OutASel.
- OutA, out, WIDTH, selected register value; feeds ALU A.
- OutB, out, WIDTH, selected register value; feeds ALU B.

## Operation

- Eight WIDTH-bit registers: R1–R4 and T1–T4.
- Every register whose RSel or TSel bit is 1 at a rising CLK edge applies FunSel:
  - Decrement: reg ← reg − 1, modulo 2^WIDTH (00 → FF).
  - Increment: reg ← reg + 1, modulo 2^WIDTH (FF → 00).
  - Load: reg ← I.
  - Clear: reg ← 0.
- Registers whose enable bit is 0 hold their value.
- If all RSel and TSel bits are 0, no register changes, whatever FunSel is.
- Several enables may be active in the same cycle:
  - All selected registers apply the same FunSel.
  - Inc/dec act independently on each register's own value.
  - Load writes the same I into every selected register.
- No flags are generated here; carry and overflow belong to the ALU.
- Read ports:
  - OutA and OutB are purely combinational muxes of the current register contents.
  - Both ports may select the same register.
  - There is no read enable and no high-Z state.
- Each register is a small state element with four update modes plus hold.

## Timing

- Reset:
  - ResetN = 0 clears all eight registers immediately, without waiting for CLK.
  - While ResetN = 0, OutA = OutB = 0 for any select value, and the register update is overridden.
  - Writes resume on the first rising CLK edge after ResetN returns to 1.
  - Reset asserted between edges, including mid-way through a multi-cycle load/increment sequence, discards the sequence; registers read 0.
- Write latency:
  - An operation set up before edge k is visible on OutA/OutB after edge k, within combinational mux delay.
  - There is no further pipeline stage.
- Read-during-write: a register both selected for output and enabled for write shows its old value until the edge, then the new value. There is no bypass of I to OutA/OutB.
- Select changes: OutASel/OutBSel changes propagate combinationally in the same cycle; no clock is needed.
- Inputs must be stable at the rising edge: I, FunSel, RSel, TSel.
- Loop-back ALU path: the register → ALU → I → register path must close in one clock period.
  - Example: OutALU fed to I with FunSel = 10.
  - A read-modify-write completes in one cycle.

## Test plan

- Reset check: assert ResetN = 0 mid-cycle after loading R1 = 3C, then release. Required: OutA = 00 for all OutASel values while reset is low; R1 reads 00 after release.
- Load and read: I = 05, FunSel = 10, RSel = 0001, one edge; then I = 02, TSel = 0010, one edge; OutASel = 100, OutBSel = 001. Required: OutA = 05, OutB = 02, matching ALU stimulus A = 05, B = 02.
- Wrap-around:
  - Load R2 = FF, then FunSel = 01 with RSel = 0010 for one edge. Required: R2 = 00.
  - Then FunSel = 00 for one edge. Required: R2 = FF.
- Multi-select and hold:
  - Load T1 = 10, T3 = 20, R4 = 7F.
  - FunSel = 01, TSel = 0101, RSel = 0000, one edge. Required: T1 = 11, T3 = 21, R4 = 7F unchanged.
  - Then FunSel = 11 with all enables 0. Required: no register changes.
- Read-during-write and loop-back:
  - Set R1 = 7F, OutASel = 100, OutBSel = 100.
  - Load R1 from I = 80 on one edge. Required: OutA shows 7F before the edge and 80 after; OutA = OutB at all times.

Source files
------------

// File: rtl/alu_reg_file_if.sv
// Bus bundle between the register-file stage and its driver: load data,
// function/enable controls, and the two combinational read ports.
interface alu_reg_file_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] I;
   logic [1:0]       FunSel;
   logic [3:0]       RSel;
   logic [3:0]       TSel;
   logic [2:0]       OutASel;
   logic [2:0]       OutBSel;
   logic [WIDTH-1:0] OutA;
   logic [WIDTH-1:0] OutB;

   modport master (
      output I, FunSel, RSel, TSel, OutASel, OutBSel,
      input  OutA, OutB
   );

   modport slave (
      input  I, FunSel, RSel, TSel, OutASel, OutBSel,
      output OutA, OutB
   );
endinterface

// File: rtl/alu_reg_file.sv
// Eight-entry register file (T1-T4, R1-R4) feeding the ALU operand ports;
// every enabled register applies the shared dec/inc/load/clear function.
module alu_reg_file #(
   parameter int WIDTH = 8
) (
   input logic           CLK,
   input logic           ResetN,
   alu_reg_file_if.slave bus
);

   typedef enum logic [1:0] {
      FN_DEC  = 2'b00,
      FN_INC  = 2'b01,
      FN_LOAD = 2'b10,
      FN_CLR  = 2'b11
   } fun_e;

   // Storage index matches the read-select encoding: 0-3 = T1-T4, 4-7 = R1-R4.
   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] regs_d [8];
   logic [7:0]       wr_en;
   fun_e             fun;

   assign wr_en = {bus.RSel, bus.TSel};
   assign fun   = fun_e'(bus.FunSel);

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en[i]) begin
            unique case (fun)
               FN_DEC:  regs_d[i] = regs_q[i] - WIDTH'(1);
               FN_INC:  regs_d[i] = regs_q[i] + WIDTH'(1);
               FN_LOAD: regs_d[i] = bus.I;
               FN_CLR:  regs_d[i] = '0;
               default: regs_d[i] = regs_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign bus.OutA = regs_q[bus.OutASel];
   assign bus.OutB = regs_q[bus.OutBSel];

endmodule

// File: tb/tb_alu_reg_file.sv
// Randomized and directed checks of alu_reg_file against a plain-array model.
`timescale 1ns/1ps
module tb_alu_reg_file;

   logic CLK;
   logic ResetN;
   int   n_cmp;
   int   n_err;
   logic [7:0] model [8];   // 0-3 = T1-T4, 4-7 = R1-R4

   alu_reg_file_if #(.WIDTH(8)) bus ();

   alu_reg_file #(.WIDTH(8)) dut (
      .CLK    (CLK),
      .ResetN (ResetN),
      .bus    (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #10 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 8; k++) begin
         bus.OutASel = 3'(k);
         bus.OutBSel = 3'(7 - k);
         #1;
         check(tag, bus.OutA, model[k]);
         check(tag, bus.OutB, model[7 - k]);
      end
   endtask

   task automatic model_apply(input logic [1:0] fun, input logic [3:0] rsel,
                              input logic [3:0] tsel, input logic [7:0] din);
      for (int k = 0; k < 8; k++) begin
         logic en;
         en = (k < 4) ? tsel[k] : rsel[k - 4];
         if (en) begin
            case (fun)
               2'b00: model[k] = 8'((int'(model[k]) + 255) % 256);
               2'b01: model[k] = 8'((int'(model[k]) + 1) % 256);
               2'b10: model[k] = din;
               default: model[k] = 8'h00;
            endcase
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] fun, input logic [3:0] rsel,
                        input logic [3:0] tsel, input logic [7:0] din);
      @(negedge CLK);
      bus.FunSel = fun;
      bus.RSel   = rsel;
      bus.TSel   = tsel;
      bus.I      = din;
      @(posedge CLK);
      #1;
      model_apply(fun, rsel, tsel, din);
      check_all(tag);
   endtask

   task automatic peek(input string tag, input logic [2:0] sel, input logic [7:0] exp);
      @(negedge CLK);
      bus.RSel    = 4'b0000;
      bus.TSel    = 4'b0000;
      bus.OutASel = sel;
      #2;
      check(tag, bus.OutA, exp);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int k = 0; k < 8; k++) model[k] = 8'h00;
      ResetN      = 1'b0;
      bus.I       = 8'h00;
      bus.FunSel  = 2'b00;
      bus.RSel    = 4'b0000;
      bus.TSel    = 4'b0000;
      bus.OutASel = 3'b000;
      bus.OutBSel = 3'b000;

      // Reset state
      @(posedge CLK);
      #1;
      check_all("reset_state");
      @(negedge CLK);
      ResetN = 1'b1;

      // Load and read: A = R1 = 05, B = T2 = 02
      do_op("load_r1", 2'b10, 4'b0001, 4'b0000, 8'h05);
      do_op("load_t2", 2'b10, 4'b0000, 4'b0010, 8'h02);
      @(negedge CLK);
      bus.RSel    = 4'b0000;
      bus.TSel    = 4'b0000;
      bus.OutASel = 3'b100;
      bus.OutBSel = 3'b001;
      #2;
      check("read_a_r1", bus.OutA, 8'h05);
      check("read_b_t2", bus.OutB, 8'h02);

      // Wrap-around on R2
      do_op("load_r2_ff", 2'b10, 4'b0010, 4'b0000, 8'hFF);
      do_op("inc_wrap", 2'b01, 4'b0010, 4'b0000, 8'h00);
      peek("r2_after_inc", 3'b101, 8'h00);
      do_op("dec_wrap", 2'b00, 4'b0010, 4'b0000, 8'h00);
      peek("r2_after_dec", 3'b101, 8'hFF);

      // Multi-select and hold
      do_op("load_t1", 2'b10, 4'b0000, 4'b0001, 8'h10);
      do_op("load_t3", 2'b10, 4'b0000, 4'b0100, 8'h20);
      do_op("load_r4", 2'b10, 4'b1000, 4'b0000, 8'h7F);
      do_op("multi_inc", 2'b01, 4'b0000, 4'b0101, 8'h00);
      peek("t1_multi", 3'b000, 8'h11);
      peek("t3_multi", 3'b010, 8'h21);
      peek("r4_hold", 3'b111, 8'h7F);
      do_op("clr_no_en", 2'b11, 4'b0000, 4'b0000, 8'h00);
      do_op("load_multi", 2'b10, 4'b1010, 4'b1001, 8'h5A);

      // Read-during-write on R1 with both ports selecting it
      do_op("load_r1_7f", 2'b10, 4'b0001, 4'b0000, 8'h7F);
      @(negedge CLK);
      bus.OutASel = 3'b100;
      bus.OutBSel = 3'b100;
      bus.I       = 8'h80;
      bus.FunSel  = 2'b10;
      bus.RSel    = 4'b0001;
      bus.TSel    = 4'b0000;
      #2;
      check("rdw_a_before", bus.OutA, 8'h7F);
      check("rdw_b_before", bus.OutB, 8'h7F);
      @(posedge CLK);
      #1;
      check("rdw_a_after", bus.OutA, 8'h80);
      check("rdw_b_after", bus.OutB, 8'h80);
      model[4] = 8'h80;

      // Mid-cycle reset overrides an active write and clears everything
      do_op("load_r1_3c", 2'b10, 4'b0001, 4'b0000, 8'h3C);
      @(negedge CLK);
      bus.I      = 8'hAA;
      bus.FunSel = 2'b10;
      bus.RSel   = 4'b1111;
      bus.TSel   = 4'b1111;
      #2;
      ResetN = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.OutASel = 3'(k);
         #1;
         check("reset_low_outa", bus.OutA, 8'h00);
      end
      for (int k = 0; k < 8; k++) model[k] = 8'h00;
      @(negedge CLK);
      bus.RSel = 4'b0000;
      bus.TSel = 4'b0000;
      ResetN   = 1'b1;
      #1;
      check_all("after_reset");
      do_op("resume", 2'b01, 4'b0001, 4'b0000, 8'h00);

      // Randomized operations
      for (int n = 0; n < 200; n++) begin
         logic [1:0] f;
         logic [3:0] rs;
         logic [3:0] ts;
         logic [7:0] d;
         f  = 2'($urandom_range(0, 3));
         rs = 4'($urandom);
         ts = 4'($urandom);
         d  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rs = 4'b0000;
            ts = 4'b0000;
         end
         do_op("random", f, rs, ts, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
